mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer sitting directly upstream of data_mem. It sits between the datapath (lb/lbu/lh/lhu/lw/sb/sh/sw) and data_mem's word-only cs/oe/we/addr/din/dout port.
- Converts sub-word accesses into word accesses: byte-lane extraction plus sign/zero extension for loads, read-modify-write for partial stores.
- Big-endian: byte offset 0 maps to bits 31:24.
- Request/acknowledge handshake toward the datapath; fixed-latency read wait toward memory.

Parameters:
- MEM_RD_LAT, 1, cycles from mem_addr/mem_oe valid to mem_dout valid (legal 1..7).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request valid; sampled only while ready=1
- ready  out  1  unit idle, can accept req
- wr  in  1  1=store, 0=load
- size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
- sgn  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  load result, extended; held until next load completes
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle misalign pulse (MAU_MISALIGN_CHK_EN only; else tied 0)
- mem_cs  out  1  to data_mem cs
- mem_oe  out  1  to data_mem oe
- mem_we  out  1  to data_mem we
- mem_addr  out  ADDR_W  word-aligned address (bits 1:0 = 00)
- mem_din  out  32  write data to data_mem
- mem_dout  in  32  read data from data_mem

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: ready=1, done=0, err=0, rdata=0, mem_cs=0, mem_oe=0, mem_we=0, mem_addr=0, mem_din=0. FSM=IDLE, latency counter=0.
- Reset mid-operation: immediate abort. mem_we drops asynchronously, no done, no partial write completes after rst_n falls.
- FSM states: IDLE, RD_WAIT, WR, RESP.
- IDLE: ready=1.
  - On req&ready, latch wr, size, sgn, addr, wdata.
  - Load or partial store -> RD_WAIT with counter=MEM_RD_LAT-1.
  - Word store -> WR.
- RD_WAIT: mem_cs=1, mem_oe=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Counter decrements each cycle.
  - At counter==0, capture mem_dout into internal word register.
  - Then load -> RESP; partial store -> WR.
- WR: mem_cs=1, mem_oe=0, mem_we=1 for exactly one cycle; the write commits at the closing edge.
  - mem_din = latched wdata for word stores.
  - mem_din = captured word with target lanes replaced for partial stores:
    - byte offset k replaces bits [31-8k -: 8];
    - half offset 0 replaces 31:16, half offset 2 replaces 15:0.
  - Next state: RESP.
- RESP: done=1 for one cycle. Load: rdata updated at entry to RESP. Next state: IDLE; ready reasserts the following cycle.
- Load extraction: byte lane / half lane selected as above, extended per sgn; word passes unchanged.
- Latency from accept edge to done-high cycle:
  - load = MEM_RD_LAT+1
  - word store = 2
  - partial store = MEM_RD_LAT+2
- req while ready=0 is ignored; the datapath holds req until it observes ready. Back-to-back requests are accepted in the IDLE cycle after RESP.
- Outside RD_WAIT/WR: mem_cs, mem_oe and mem_we are 0; mem_addr and mem_din hold their last value.

Optional Feature:
- MAU_MISALIGN_CHK_EN defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE -> RESP directly.
  - done=1 and err=1 in the same cycle; no memory access; rdata unchanged.
- Undefined:
  - Half: addr[0] ignored.
  - Word: addr[1:0] ignored (access truncated to alignment).
  - err tied 0.

Test Plan:
- Reset: hold rst_n=0 -> all outputs at reset values, ready=1. Release, lw 0x1000000c with mem word 0xDEADBEEF -> done after 2 cycles (MEM_RD_LAT=1), rdata=0xDEADBEEF.
- lb sgn=1 at 0x10000025, mem word 0x1280FF34 -> rdata=0xFFFFFF80. Same with sgn=0 -> 0x00000080. lhu at 0x10000026 -> 0x0000FF34.
- sb 0x000000AB at 0x10000029, mem word 0x11223344 -> single mem_we pulse, mem_din=0x11AB3344. Subsequent lw returns 0x11AB3344. Latency 3 cycles.
- sw 0x0000FF28 at 0x10000028 -> mem_we high exactly one cycle, no read phase, done 2 cycles after accept. Then sw 0x0000FF24 at 0x10000024 back-to-back; readbacks match.
- Assert rst_n=0 during WR of sh -> mem_we drops immediately, memory word unchanged on readback, no done.
- With MAU_MISALIGN_CHK_EN: lw at 0x10000002 -> done=err=1 next cycle, mem_cs never asserted. Without the macro: same request reads word 0x10000000.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian load/store sequencer in front of a word-only data memory.
// Optional misalignment trap (err pulse, no memory access) when MAU_MISALIGN_CHK_EN is defined.
module mem_access_unit #(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;
    state_t state, next;
    logic [2:0] cnt;
    logic wr_q, sgn_q;
    logic [1:0] size_q, off_q;
    logic [31:0] wdata_q, mask, load_val, merged;
    logic [15:0] fld;
    logic [4:0] sh;
    logic accept, mis, word_st;

    assign accept  = req & ready;
    assign word_st = wr & size[1];

`ifdef MAU_MISALIGN_CHK_EN
    logic err_q;
    assign mis = (size == 2'b01 & addr[0]) | (size[1] & |addr[1:0]);
    assign err = (state == RESP) & err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (accept) err_q <= mis;
    end
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = mis ? RESP : word_st ? WR : RD_WAIT;
            RD_WAIT: if (cnt == 3'd0) next = wr_q ? WR : RESP;
            WR:      next = RESP;
            default: next = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign ready  = state == IDLE;
    assign done   = state == RESP;
    assign mem_cs = (state == RD_WAIT) | (state == WR);
    assign mem_oe = state == RD_WAIT;
    assign mem_we = state == WR;

    // Byte offset 0 is the most significant lane; sh moves the target lane to/from bit 0.
    always_comb begin
        sh       = size_q[1] ? 5'd0 : size_q[0] ? {~off_q[1], 4'b0000} : {~off_q, 3'b000};
        mask     = size_q[1] ? '1 : (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        fld      = 16'(mem_dout >> sh);
        load_val = size_q[1] ? mem_dout :
                   size_q[0] ? {{16{sgn_q & fld[15]}}, fld} : {{24{sgn_q & fld[7]}}, fld[7:0]};
        merged   = (mem_dout & ~mask) | ((wdata_q << sh) & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wr_q     <= 1'b0;
            sgn_q    <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            if (accept) begin
                wr_q    <= wr;
                sgn_q   <= sgn;
                size_q  <= size;
                off_q   <= addr[1:0];
                wdata_q <= wdata;
                cnt     <= 3'(MEM_RD_LAT - 1);
                if (!mis) mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                if (!mis && word_st) mem_din <= wdata;
            end
            if (state == RD_WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd0) begin
                    if (wr_q) mem_din <= merged;
                    else rdata <= load_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table of directed accesses, a reset-during-write sequence, and random
// accesses checked against a byte-array reference model and a latency-aware memory model.
module tb_mem_access_unit;
    localparam int LAT = 2;

    logic clk = 0, rst_n = 0, req = 0, wr = 0, sgn = 0;
    logic [1:0] size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic ready, done, err, mem_cs, mem_oe, mem_we;
    logic [31:0] rdata, mem_addr, mem_din, mem_dout;

    int n_chk = 0, n_fail = 0;
    logic [31:0] mdl [0:63];
    logic [31:0] model_rd = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_RD_LAT(LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .wr(wr), .size(size), .sgn(sgn),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory: data only valid once the read has been held LAT cycles, garbage before.
    logic [31:0] mem [0:63];
    int rd_cnt = 0;
    logic pl_we = 0;
    logic [5:0] pl_idx = 0;
    logic [31:0] pl_val = 0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_val;
        else if (mem_cs && mem_we) mem[mem_addr[7:2]] <= mem_din;
        rd_cnt <= (mem_cs && mem_oe) ? rd_cnt + 1 : 0;
    end
    assign mem_dout = (mem_cs && mem_oe && rd_cnt >= LAT - 1) ? mem[mem_addr[7:2]] : 32'hBADBAD00;

    typedef struct {
        bit w; bit [1:0] sz; bit sg; logic [31:0] a; logic [31:0] wd;
        bit pre; logic [31:0] init; logic [31:0] rd; logic [31:0] emem; int lat; bit er;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pl_we = 1; pl_idx = 6'(idx); pl_val = v; mdl[idx] = v;
        @(posedge clk); #1;
        pl_we = 0;
    endtask

    function automatic bit mis(input bit [1:0] sz, input bit [1:0] off);
`ifdef MAU_MISALIGN_CHK_EN
        return (sz == 2'b01 && off[0]) || (sz[1] && off != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input bit [1:0] sz,
                                             input bit sg, input bit [1:0] off);
        logic [7:0] b [4];
        int h;
        logic [15:0] hv;
        for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
        h = (off >= 2) ? 2 : 0;
        hv = {b[h], b[h+1]};
        if (sz == 2'b00) return sg ? {{24{b[off][7]}}, b[off]} : {24'b0, b[off]};
        if (sz == 2'b01) return sg ? {{16{hv[15]}}, hv} : {16'b0, hv};
        return word;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input bit [1:0] sz,
                                              input bit [1:0] off, input logic [31:0] wd);
        logic [7:0] b [4];
        int h;
        for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
        h = (off >= 2) ? 2 : 0;
        if (sz[1]) return wd;
        if (sz == 2'b00) b[off] = wd[7:0];
        else begin
            b[h] = wd[15:8];
            b[h+1] = wd[7:0];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic do_op(input bit w, input bit [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat,
                         output int we_n, output int cs_n, output logic [31:0] din,
                         output bit er, output bit abad);
        int k;
        rd = '0; lat = 0; we_n = 0; cs_n = 0; din = '0; er = 0; abad = 0; k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", {31'b0, ready}, 32'd1);
        req = 1; wr = w; size = sz; sgn = sg; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 0; wr = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        for (int i = 1; i <= 20; i++) begin
            if (mem_cs) begin
                cs_n++;
                if (mem_addr !== {a[31:2], 2'b00}) abad = 1;
            end
            if (mem_we) begin
                we_n++;
                din = mem_din;
            end
            if (done) begin
                lat = i; rd = rdata; er = err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_op(input string nm, input bit w, input bit [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                            input logic [31:0] emem, input int elat, input bit eer);
        logic [31:0] rd, din;
        int lat, we_n, cs_n, ecs, ewe;
        bit er, abad, m;
        m = mis(sz, a[1:0]);
        ecs = m ? 0 : (w && sz[1]) ? 1 : w ? LAT + 1 : LAT;
        ewe = (!m && w) ? 1 : 0;
        do_op(w, sz, sg, a, wd, rd, lat, we_n, cs_n, din, er, abad);
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_err"}, {31'b0, er}, {31'b0, eer});
        chk({nm, "_cs_cycles"}, 32'(cs_n), 32'(ecs));
        chk({nm, "_we_cycles"}, 32'(we_n), 32'(ewe));
        chk({nm, "_addr_bad"}, {31'b0, abad}, 32'd0);
        chk({nm, "_mem"}, mem[a[7:2]], emem);
        if (ewe == 1) chk({nm, "_din"}, din, emem);
        model_rd = erd;
    endtask

    task automatic add(input bit w, input bit [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input bit pre, input logic [31:0] init,
                       input logic [31:0] rd, input logic [31:0] emem, input int lat, input bit er);
        vec_t v;
        v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.pre = pre; v.init = init;
        v.rd = rd; v.emem = emem; v.lat = lat; v.er = er;
        tbl.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit w, sg, m;
        bit [1:0] sz;
        logic [31:0] a, wd, erd, emem, nw;
        int idx, k;

        add(0, 2'b10, 0, 32'h1000000C, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, LAT + 1, 0);
        add(0, 2'b00, 1, 32'h10000025, 0, 1, 32'h1280FF34, 32'hFFFFFF80, 32'h1280FF34, LAT + 1, 0);
        add(0, 2'b00, 0, 32'h10000025, 0, 0, 0, 32'h00000080, 32'h1280FF34, LAT + 1, 0);
        add(0, 2'b01, 0, 32'h10000026, 0, 0, 0, 32'h0000FF34, 32'h1280FF34, LAT + 1, 0);
        add(1, 2'b00, 0, 32'h10000029, 32'h000000AB, 1, 32'h11223344, 32'h0000FF34, 32'h11AB3344, LAT + 2, 0);
        add(0, 2'b10, 0, 32'h10000028, 0, 0, 0, 32'h11AB3344, 32'h11AB3344, LAT + 1, 0);
        add(1, 2'b10, 0, 32'h10000028, 32'h0000FF28, 0, 0, 32'h11AB3344, 32'h0000FF28, 2, 0);
        add(1, 2'b10, 0, 32'h10000024, 32'h0000FF24, 0, 0, 32'h11AB3344, 32'h0000FF24, 2, 0);
        add(0, 2'b10, 0, 32'h10000028, 0, 0, 0, 32'h0000FF28, 32'h0000FF28, LAT + 1, 0);
        add(0, 2'b10, 0, 32'h10000024, 0, 0, 0, 32'h0000FF24, 32'h0000FF24, LAT + 1, 0);
        add(1, 2'b01, 0, 32'h10000032, 32'h12348001, 1, 32'hAABBCCDD, 32'h0000FF24, 32'hAABB8001, LAT + 2, 0);
        add(0, 2'b01, 1, 32'h10000032, 0, 0, 0, 32'hFFFF8001, 32'hAABB8001, LAT + 1, 0);
        add(0, 2'b01, 1, 32'h10000030, 0, 0, 0, 32'hFFFFAABB, 32'hAABB8001, LAT + 1, 0);
        add(1, 2'b11, 0, 32'h10000034, 32'h12345678, 1, 0, 32'hFFFFAABB, 32'h12345678, 2, 0);
        add(1, 2'b00, 0, 32'h1000003B, 32'h123456EE, 1, 0, 32'hFFFFAABB, 32'h000000EE, LAT + 2, 0);
        add(0, 2'b00, 1, 32'h1000003B, 0, 0, 0, 32'hFFFFFFEE, 32'h000000EE, LAT + 1, 0);
        add(0, 2'b00, 1, 32'h10000038, 0, 0, 0, 32'h00000000, 32'h000000EE, LAT + 1, 0);
`ifdef MAU_MISALIGN_CHK_EN
        add(0, 2'b10, 0, 32'h10000002, 0, 1, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 1, 1);
        add(0, 2'b01, 0, 32'h10000037, 0, 0, 0, 32'h00000000, 32'h12345678, 1, 1);
`else
        add(0, 2'b10, 0, 32'h10000002, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, LAT + 1, 0);
        add(0, 2'b01, 0, 32'h10000037, 0, 0, 0, 32'h00005678, 32'h12345678, LAT + 1, 0);
`endif

        rst_n = 0; req = 1; wr = 1; size = 2'b10; addr = 32'h10000010; wdata = 32'h5A5A5A5A;
        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", {29'b0, mem_cs, mem_oe, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        req = 0;
        rst_n = 1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].pre) preload(int'(tbl[i].a[7:2]), tbl[i].init);
            check_op($sformatf("tbl%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                     tbl[i].rd, tbl[i].emem, tbl[i].lat, tbl[i].er);
        end

        // Reset while a half-word store sits in its write cycle.
        preload(16, 32'h55667788);
        req = 1; wr = 1; size = 2'b01; sgn = 0; addr = 32'h10000040; wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req = 0;
        k = 0;
        while (!mem_we && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rstwr_we_seen", {31'b0, mem_we}, 32'd1);
        rst_n = 0;
        #1;
        chk("rstwr_we_drop", {31'b0, mem_we}, 32'd0);
        chk("rstwr_cs_drop", {31'b0, mem_cs}, 32'd0);
        chk("rstwr_ready", {31'b0, ready}, 32'd1);
        chk("rstwr_rdata", rdata, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstwr_no_done", {31'b0, done}, 32'd0);
        end
        chk("rstwr_mem_kept", mem[16], 32'h55667788);
        rst_n = 1;
        model_rd = 0;
        @(posedge clk); #1;
        check_op("rstwr_readback", 0, 2'b10, 0, 32'h10000040, 0, 32'h55667788, 32'h55667788, LAT + 1, 0);

        for (int i = 0; i < 16; i++) preload(i, $urandom);
        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); wd = $urandom;
            a = 32'h10000000 | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            idx = int'(a[7:2]);
            m = mis(sz, a[1:0]);
            if (m) begin
                erd = model_rd; emem = mdl[idx];
            end else if (!w) begin
                erd = ref_load(mdl[idx], sz, sg, a[1:0]); emem = mdl[idx];
            end else begin
                nw = ref_store(mdl[idx], sz, a[1:0], wd);
                mdl[idx] = nw; erd = model_rd; emem = nw;
            end
            check_op($sformatf("rnd%0d", n), w, sz, sg, a, wd, erd, emem,
                     m ? 1 : !w ? LAT + 1 : sz[1] ? 2 : LAT + 2, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
